neuron_input_feeder: RTL and testbench

NEURON_INPUT_FEEDER -- requirements
Module: neuron_input_feeder

---
 rtl/neuron_input_feeder_if.sv | 25 ++
 rtl/neuron_input_feeder.sv | 210 +++++++++++++++++++++
 tb/tb_neuron_input_feeder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_input_feeder_if.sv
// Beat bus from the input feeder to the neuron processor.
// The feeder drives the beat and its valids; the processor answers with rd_en.
interface neuron_input_feeder_if #(
  parameter int PARALLEL_INPUTS = 1,
  parameter int AW_T            = 1
);
  logic [PARALLEL_INPUTS-1:0] inputs;
  logic [PARALLEL_INPUTS-1:0] weights;
  logic [31:0]                threshold;
  logic                       inputs_valid;
  logic                       weights_valid;
  logic                       rd_en;
  logic                       last_beat;
  logic [AW_T-1:0]            neuron_idx;

  modport master (
    output inputs, weights, threshold, inputs_valid, weights_valid, last_beat, neuron_idx,
    input  rd_en
  );

  modport slave (
    input  inputs, weights, threshold, inputs_valid, weights_valid, last_beat, neuron_idx,
    output rd_en
  );
endinterface

// File: rtl/neuron_input_feeder.sv
// Streams activation/weight/threshold beats for every neuron of a run from three
// 1-cycle-latency RAMs into a 2-entry FIFO that feeds the neuron processor.
module neuron_input_feeder #(
  parameter int PARALLEL_INPUTS = 1,
  parameter int NUM_INPUTS      = 2,
  parameter int NUM_NEURONS     = 2,
  localparam int BEATS = (NUM_INPUTS + PARALLEL_INPUTS - 1) / PARALLEL_INPUTS,
  localparam int AW_A  = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int AW_W  = (NUM_NEURONS * BEATS > 1) ? $clog2(NUM_NEURONS * BEATS) : 1,
  localparam int AW_T  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [AW_A-1:0]            act_rd_addr,
  input  logic [PARALLEL_INPUTS-1:0] act_rd_data,
  output logic [AW_W-1:0]            wt_rd_addr,
  input  logic [PARALLEL_INPUTS-1:0] wt_rd_data,
  output logic [AW_T-1:0]            thr_rd_addr,
  input  logic [31:0]                thr_rd_data,
  neuron_input_feeder_if.master      beat
);

  localparam int              REM    = NUM_INPUTS % PARALLEL_INPUTS;
  localparam logic [AW_A-1:0] B_LAST = AW_A'(BEATS - 1);
  localparam logic [AW_T-1:0] N_LAST = AW_T'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [AW_A-1:0]            b_q, b_d;
  logic [AW_T-1:0]            n_q, n_d;
  logic [AW_W-1:0]            w_q, w_d;
  logic                       done_q, done_d;

  // Read in flight: RAM data appears the cycle after issue.
  logic                       rf_q, rf_d;
  logic                       rf_last_q, rf_last_d;
  logic [AW_T-1:0]            rf_n_q, rf_n_d;

  logic [PARALLEL_INPUTS-1:0] fifo_in_q   [2];
  logic [PARALLEL_INPUTS-1:0] fifo_in_d   [2];
  logic [PARALLEL_INPUTS-1:0] fifo_wt_q   [2];
  logic [PARALLEL_INPUTS-1:0] fifo_wt_d   [2];
  logic [31:0]                fifo_thr_q  [2];
  logic [31:0]                fifo_thr_d  [2];
  logic                       fifo_last_q [2];
  logic                       fifo_last_d [2];
  logic [AW_T-1:0]            fifo_n_q    [2];
  logic [AW_T-1:0]            fifo_n_d    [2];
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 cnt_q, cnt_d;

  logic                       head_valid;
  logic                       pop;
  logic                       final_xfer;
  logic                       issue;
  logic                       is_last_b;
  logic                       is_final_rd;
  logic [PARALLEL_INPUTS-1:0] push_in;
  logic [PARALLEL_INPUTS-1:0] push_wt;

  assign head_valid  = (cnt_q != 2'd0);
  assign pop         = head_valid && beat.rd_en;
  assign final_xfer  = pop && fifo_last_q[rd_ptr_q] && (fifo_n_q[rd_ptr_q] == N_LAST);
  // Slot freed by this cycle's pop counts, so a full pipeline keeps 1 beat/cycle.
  assign issue       = (state_q == RUN) &&
                       ((int'(cnt_q) + int'(rf_q) - int'(pop)) < 2);
  assign is_last_b   = (b_q == B_LAST);
  assign is_final_rd = is_last_b && (n_q == N_LAST);

  always_comb begin
    push_in = act_rd_data;
    push_wt = wt_rd_data;
    // Pad lanes past the end of the neuron: XNOR(1,0)=0 adds nothing.
    if (rf_last_q && (REM != 0)) begin
      for (int i = REM; i < PARALLEL_INPUTS; i++) begin
        push_in[i] = 1'b1;
        push_wt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    n_d       = n_q;
    w_d       = w_q;
    done_d    = 1'b0;
    rf_d      = issue;
    rf_last_d = rf_last_q;
    rf_n_d    = rf_n_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          b_d     = '0;
          n_d     = '0;
          w_d     = '0;
        end
      end
      RUN: begin
        if (issue) begin
          rf_last_d = is_last_b;
          rf_n_d    = n_q;
          if (is_final_rd) begin
            b_d     = '0;
            n_d     = '0;
            w_d     = '0;
            state_d = DRAIN;
          end else if (is_last_b) begin
            b_d = '0;
            n_d = n_q + 1'b1;
            w_d = w_q + 1'b1;
          end else begin
            b_d = b_q + 1'b1;
            w_d = w_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (final_xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_in_d   = fifo_in_q;
    fifo_wt_d   = fifo_wt_q;
    fifo_thr_d  = fifo_thr_q;
    fifo_last_d = fifo_last_q;
    fifo_n_d    = fifo_n_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + {1'b0, rf_q} - {1'b0, pop};
    if (rf_q) begin
      fifo_in_d[wr_ptr_q]   = push_in;
      fifo_wt_d[wr_ptr_q]   = push_wt;
      fifo_thr_d[wr_ptr_q]  = thr_rd_data;
      fifo_last_d[wr_ptr_q] = rf_last_q;
      fifo_n_d[wr_ptr_q]    = rf_n_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      b_q       <= '0;
      n_q       <= '0;
      w_q       <= '0;
      done_q    <= 1'b0;
      rf_q      <= 1'b0;
      rf_last_q <= 1'b0;
      rf_n_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_in_q[i]   <= '0;
        fifo_wt_q[i]   <= '0;
        fifo_thr_q[i]  <= '0;
        fifo_last_q[i] <= 1'b0;
        fifo_n_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      n_q         <= n_d;
      w_q         <= w_d;
      done_q      <= done_d;
      rf_q        <= rf_d;
      rf_last_q   <= rf_last_d;
      rf_n_q      <= rf_n_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      fifo_in_q   <= fifo_in_d;
      fifo_wt_q   <= fifo_wt_d;
      fifo_thr_q  <= fifo_thr_d;
      fifo_last_q <= fifo_last_d;
      fifo_n_q    <= fifo_n_d;
    end
  end

  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign act_rd_addr        = b_q;
  assign wt_rd_addr         = w_q;
  assign thr_rd_addr        = n_q;
  assign beat.inputs_valid  = head_valid;
  assign beat.weights_valid = head_valid;
  assign beat.inputs        = fifo_in_q[rd_ptr_q];
  assign beat.weights       = fifo_wt_q[rd_ptr_q];
  assign beat.threshold     = fifo_thr_q[rd_ptr_q];
  assign beat.last_beat     = fifo_last_q[rd_ptr_q];
  assign beat.neuron_idx    = fifo_n_q[rd_ptr_q];

endmodule

// File: tb/tb_neuron_input_feeder.sv
// Directed bench for neuron_input_feeder: three instances cover the basic run,
// backpressure, reset mid-run, start-while-busy, partial last beat and throughput.
module tb_neuron_input_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // A: PI=1 NI=2 NN=2
  logic        start_a, busy_a, done_a;
  logic [0:0]  a_act_addr, a_act_data, a_wt_data, a_thr_addr;
  logic [1:0]  a_wt_addr;
  logic [31:0] a_thr_data;
  logic [1:0]  act_a_mem = 2'b01;
  logic [3:0]  wt_a_mem  = 4'b0011;
  logic [31:0] thr_a_mem [2] = '{32'd2, 32'd1};
  neuron_input_feeder_if #(.PARALLEL_INPUTS(1), .AW_T(1)) a_if ();

  // B: PI=2 NI=5 NN=1
  logic        start_b, busy_b, done_b;
  logic [1:0]  b_act_addr, b_act_data, b_wt_addr, b_wt_data;
  logic [0:0]  b_thr_addr;
  logic [31:0] b_thr_data;
  logic [1:0]  act_b_mem [3] = '{2'b10, 2'b01, 2'b00};
  logic [1:0]  wt_b_mem  [3] = '{2'b11, 2'b10, 2'b11};
  logic [31:0] thr_b_mem [2] = '{32'd7, 32'd0};
  neuron_input_feeder_if #(.PARALLEL_INPUTS(2), .AW_T(1)) b_if ();

  // C: PI=1 NI=8 NN=1
  logic        start_c, busy_c, done_c;
  logic [2:0]  c_act_addr, c_wt_addr;
  logic [0:0]  c_act_data, c_wt_data, c_thr_addr;
  logic [31:0] c_thr_data;
  logic [7:0]  act_c_mem = 8'b1011_0010;
  logic [7:0]  wt_c_mem  = 8'b0110_1101;
  logic [31:0] thr_c_mem [2] = '{32'd5, 32'd0};
  neuron_input_feeder_if #(.PARALLEL_INPUTS(1), .AW_T(1)) c_if ();

  always @(posedge clk) begin
    a_act_data <= act_a_mem[a_act_addr];
    a_wt_data  <= wt_a_mem[a_wt_addr];
    a_thr_data <= thr_a_mem[a_thr_addr];
    b_act_data <= act_b_mem[b_act_addr];
    b_wt_data  <= wt_b_mem[b_wt_addr];
    b_thr_data <= thr_b_mem[b_thr_addr];
    c_act_data <= act_c_mem[c_act_addr];
    c_wt_data  <= wt_c_mem[c_wt_addr];
    c_thr_data <= thr_c_mem[c_thr_addr];
  end

  neuron_input_feeder #(.PARALLEL_INPUTS(1), .NUM_INPUTS(2), .NUM_NEURONS(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .act_rd_addr(a_act_addr), .act_rd_data(a_act_data),
    .wt_rd_addr(a_wt_addr), .wt_rd_data(a_wt_data),
    .thr_rd_addr(a_thr_addr), .thr_rd_data(a_thr_data), .beat(a_if));

  neuron_input_feeder #(.PARALLEL_INPUTS(2), .NUM_INPUTS(5), .NUM_NEURONS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .act_rd_addr(b_act_addr), .act_rd_data(b_act_data),
    .wt_rd_addr(b_wt_addr), .wt_rd_data(b_wt_data),
    .thr_rd_addr(b_thr_addr), .thr_rd_data(b_thr_data), .beat(b_if));

  neuron_input_feeder #(.PARALLEL_INPUTS(1), .NUM_INPUTS(8), .NUM_NEURONS(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .act_rd_addr(c_act_addr), .act_rd_data(c_act_data),
    .wt_rd_addr(c_wt_addr), .wt_rd_data(c_wt_data),
    .thr_rd_addr(c_thr_addr), .thr_rd_data(c_thr_data), .beat(c_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] beat_a_now();
    return {a_if.inputs, a_if.weights, a_if.threshold, a_if.last_beat, a_if.neuron_idx};
  endfunction

  // Waits (bounded) for a valid beat on A, checks it, then lets it transfer.
  task automatic expect_a(input string tag, input logic iv, input logic wv,
                          input logic [31:0] thr, input logic last, input logic idx);
    int n = 0;
    while (a_if.inputs_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " valid"}, {a_if.inputs_valid, a_if.weights_valid}, 2'b11);
    chk({tag, " beat"}, beat_a_now(), {iv, wv, thr, last, idx});
    tick();
  endtask

  task automatic expect_b(input string tag, input logic [1:0] iv, input logic [1:0] wv,
                          input logic last);
    int n = 0;
    while (b_if.inputs_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " valid"}, {b_if.inputs_valid, b_if.weights_valid}, 2'b11);
    chk({tag, " beat"}, {b_if.inputs, b_if.weights, b_if.threshold, b_if.last_beat, b_if.neuron_idx},
        {iv, wv, 32'd7, last, 1'b0});
    tick();
  endtask

  task automatic chk_reset_a(input string tag);
    chk(tag, {a_if.inputs_valid, a_if.weights_valid, busy_a, done_a, a_if.last_beat,
              a_if.neuron_idx, a_if.inputs, a_if.weights, a_if.threshold,
              a_act_addr, a_wt_addr, a_thr_addr}, 64'd0);
  endtask

  logic [35:0] exp_a [4];
  int          ecount, dcount;

  initial begin
    exp_a[0] = {1'b1, 1'b1, 32'd2, 1'b0, 1'b0};
    exp_a[1] = {1'b0, 1'b1, 32'd2, 1'b1, 1'b0};
    exp_a[2] = {1'b1, 1'b0, 32'd1, 1'b0, 1'b1};
    exp_a[3] = {1'b0, 1'b0, 32'd1, 1'b1, 1'b1};
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    a_if.rd_en = 1'b1; b_if.rd_en = 1'b1; c_if.rd_en = 1'b1;
    tick(); tick();
    chk_reset_a("reset A");
    chk("reset B", {b_if.inputs_valid, busy_b, done_b, b_if.inputs, b_if.weights, b_if.threshold,
                    b_act_addr, b_wt_addr}, 64'd0);
    chk("reset C", {c_if.inputs_valid, busy_c, done_c, c_if.threshold, c_act_addr, c_wt_addr}, 64'd0);
    rst = 1'b0;
    tick();

    // Basic run with exact fill latency and back-to-back beats
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("A busy after start", {busy_a, a_if.inputs_valid}, 2'b10);
    tick();
    chk("A fill cycle 1", a_if.inputs_valid, 1'b0);
    tick();
    chk("A fill cycle 2", a_if.inputs_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("A stream valid", a_if.inputs_valid, 1'b1);
      chk("A stream beat", beat_a_now(), exp_a[k]);
      tick();
    end
    chk("A done pulse", {done_a, busy_a, a_if.inputs_valid}, 3'b100);

    // Start on the done cycle, plus a start while busy that must be ignored
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("A start on done", {done_a, busy_a}, 2'b01);
    ecount = 0; dcount = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (a_if.inputs_valid === 1'b1 && a_if.rd_en === 1'b1) begin
        if (ecount < 4) chk("A rerun beat order", beat_a_now(), exp_a[ecount]);
        ecount++;
      end
      if (done_a === 1'b1) dcount++;
      start_a = (cyc == 3);
      tick();
    end
    start_a = 1'b0;
    chk("A rerun beat count", ecount, 4);
    chk("A rerun done count", dcount, 1);

    // Backpressure: hold second beat for 3 cycles
    start_a = 1'b1; tick(); start_a = 1'b0;
    expect_a("A bp b0", 1'b1, 1'b1, 32'd2, 1'b0, 1'b0);
    a_if.rd_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("A bp hold valid", a_if.inputs_valid, 1'b1);
      chk("A bp hold beat", beat_a_now(), exp_a[1]);
      tick();
    end
    a_if.rd_en = 1'b1;
    expect_a("A bp b1", 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
    expect_a("A bp b2", 1'b1, 1'b0, 32'd1, 1'b0, 1'b1);
    expect_a("A bp b3", 1'b0, 1'b0, 32'd1, 1'b1, 1'b1);
    chk("A bp done, no extra beat", {done_a, a_if.inputs_valid}, 2'b10);
    tick();

    // Reset mid-run after two transfers
    start_a = 1'b1; tick(); start_a = 1'b0;
    expect_a("A mid b0", 1'b1, 1'b1, 32'd2, 1'b0, 1'b0);
    expect_a("A mid b1", 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_reset_a("A reset mid-run");
    rst = 1'b0;
    tick();
    chk_reset_a("A idle after reset");
    start_a = 1'b1; tick(); start_a = 1'b0;
    expect_a("A restart b0", 1'b1, 1'b1, 32'd2, 1'b0, 1'b0);
    expect_a("A restart b1", 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
    expect_a("A restart b2", 1'b1, 1'b0, 32'd1, 1'b0, 1'b1);
    expect_a("A restart b3", 1'b0, 1'b0, 32'd1, 1'b1, 1'b1);
    chk("A restart done", {done_a, busy_a}, 2'b10);

    // Partial last beat: lane 1 padded to inputs=1, weights=0
    start_b = 1'b1; tick(); start_b = 1'b0;
    expect_b("B b0", 2'b10, 2'b11, 1'b0);
    expect_b("B b1", 2'b01, 2'b10, 1'b0);
    expect_b("B b2", 2'b10, 2'b01, 1'b1);
    chk("B done", {done_b, busy_b, b_if.inputs_valid}, 3'b100);

    // Throughput: 8 beats on 8 consecutive cycles after a 2-cycle fill
    start_c = 1'b1; tick(); start_c = 1'b0;
    chk("C fill cycle 0", {busy_c, c_if.inputs_valid}, 2'b10);
    tick();
    chk("C fill cycle 1", c_if.inputs_valid, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("C stream valid", {c_if.inputs_valid, c_if.weights_valid}, 2'b11);
      chk("C stream beat", {c_if.inputs, c_if.weights, c_if.threshold, c_if.last_beat},
          {act_c_mem[k], wt_c_mem[k], 32'd5, (k == 7)});
      tick();
    end
    chk("C done", {done_c, busy_c, c_if.inputs_valid}, 3'b100);
    tick();
    chk("C done one cycle", done_c, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
